// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking layers: MAC FSM states, output range
// limits and the saturating narrow to the 8-bit neuron input.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mac_state_e;

  localparam int MAC_OUT_MAX = 127;
  localparam int MAC_OUT_MIN = -128;

  // Callers sign-extend the accumulator to 32 bits before calling.
  function automatic logic signed [7:0] sat_to_8(input logic signed [31:0] v);
    if (v > MAC_OUT_MAX) begin
      return 8'(MAC_OUT_MAX);
    end else if (v < MAC_OUT_MIN) begin
      return 8'(MAC_OUT_MIN);
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/weight_regfile.sv
// N_IN x W_WIDTH synaptic weight registers: one write port, one combinational
// read port (a same-cycle write to the read index returns the old value).
module weight_regfile #(
  parameter  int N_IN    = 16,
  parameter  int W_WIDTH = 8,
  localparam int AW      = $clog2(N_IN)
) (
  input  logic               clk_i,
  input  logic               clr_n_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [W_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [W_WIDTH-1:0] rdata_o
);

  logic [W_WIDTH-1:0] mem_q [N_IN];

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < N_IN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spike_mac.sv
// Serial weighted-spike accumulator: snapshots spk_in on pulse, sums one weight
// per cycle, then presents the saturated 8-bit sum with a one-cycle valid.
module spike_mac
  import snn_pkg::*;
#(
  parameter  int N_IN      = 16,
  parameter  int W_WIDTH   = 8,
  parameter  int ACC_WIDTH = 12,
  localparam int IW        = $clog2(N_IN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse,
  input  logic [N_IN-1:0]    spk_in,
  input  logic               w_we,
  input  logic [IW-1:0]      w_addr,
  input  logic [W_WIDTH-1:0] w_data,
  output logic [7:0]         mac_out,
  output logic               mac_valid,
  output logic               busy,
  output logic               overrun
);

  mac_state_e                  state_q, state_d;
  logic [N_IN-1:0]             snap_q, snap_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]                  mac_out_q, mac_out_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        ovr_q, ovr_d;

  logic [W_WIDTH-1:0]          w_rd_dat;
  logic signed [W_WIDTH-1:0]   w_rd;
  logic signed [ACC_WIDTH-1:0] w_ext;

  weight_regfile #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH)
  ) u_weights (
    .clk_i   (clk),
    .clr_n_i (reset),
    .we_i    (w_we),
    .waddr_i (w_addr),
    .wdata_i (w_data),
    .raddr_i (idx_q),
    .rdata_o (w_rd_dat)
  );

  assign w_rd  = w_rd_dat;
  assign w_ext = ACC_WIDTH'(w_rd);

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mac_out_d = mac_out_q;
    valid_d   = 1'b0;
    // A pulse that cannot start a new sum (including one landing on DONE) is lost.
    ovr_d     = ovr_q | (pulse && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (pulse) begin
          state_d = ST_ACCUM;
          snap_d  = spk_in;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (snap_q[idx_q]) begin
          acc_d = acc_q + w_ext;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N_IN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mac_out_d = sat_to_8(32'(acc_q));
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy stays up through the valid cycle so a new pulse there is visible upstream.
    busy_d = (state_d != ST_IDLE) || valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      mac_out_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      mac_out_q <= mac_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mac_out   = mac_out_q;
  assign mac_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spike_mac.sv
// Directed and randomized checks of spike_mac against an arithmetic model of
// the weighted spike sum with 8-bit saturation.
module tb_spike_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        pulse;
  logic [15:0] spk_in;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic [7:0]  mac_out;
  logic        mac_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int w_m [16];

  spike_mac dut (
    .clk       (clk),
    .reset     (reset),
    .pulse     (pulse),
    .spk_in    (spk_in),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .mac_out   (mac_out),
    .mac_valid (mac_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_sum(input logic [15:0] s);
    int a = 0;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) a += w_m[i];
    end
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return a;
  endfunction

  task automatic write_w(input int idx, input int val);
    logic [7:0] v;
    v      = 8'(val);
    w_we   = 1'b1;
    w_addr = 4'(idx);
    w_data = v;
    tick();
    w_we   = 1'b0;
    w_m[idx] = int'($signed(v));
  endtask

  task automatic do_pulse(input logic [15:0] s);
    spk_in = s;
    pulse  = 1'b1;
    tick();
    pulse  = 1'b0;
  endtask

  // Ticks until mac_valid is seen; lat is the tick count, or -1 if the budget expires.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mac_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mac_valid) cnt++;
    end
  endtask

  initial begin
    int         lat;
    int         cnt;
    int         exp;
    logic [15:0] s;
    logic [7:0]  r;

    reset  = 1'b0;
    pulse  = 1'b0;
    spk_in = '0;
    w_we   = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < 16; i++) w_m[i] = 0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_mac_out", 32'($signed(mac_out)), 0);
    chk("rst_valid", 32'(mac_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // All weights +1, all spikes: sum 16 with the documented latency.
    for (int i = 0; i < 16; i++) write_w(i, 1);
    do_pulse(16'hFFFF);
    chk("busy_after_pulse", 32'(busy), 1);
    wait_valid(lat);
    chk("latency", lat, 17);
    chk("ones_sum", 32'($signed(mac_out)), 16);
    chk("busy_in_valid", 32'(busy), 1);
    tick();
    chk("valid_one_cycle", 32'(mac_valid), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("mac_out_hold", 32'($signed(mac_out)), 16);

    // Signed weights; spk_in changed after the pulse must not matter.
    for (int i = 0; i < 16; i++) write_w(i, i - 8);
    do_pulse(16'h00F0);
    spk_in = 16'hFFFF;
    wait_valid(lat);
    chk("signed_sum", 32'($signed(mac_out)), -10);
    chk("signed_sum_model", 32'($signed(mac_out)), model_sum(16'h00F0));

    for (int i = 0; i < 16; i++) write_w(i, 100);
    do_pulse(16'hFFFF);
    wait_valid(lat);
    chk("sat_pos", 32'($signed(mac_out)), 127);
    for (int i = 0; i < 16; i++) write_w(i, -128);
    do_pulse(16'hFFFF);
    wait_valid(lat);
    chk("sat_neg", 32'($signed(mac_out)), -128);

    // Overrun: second pulse five cycles after the first.
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom);
      write_w(i, int'($signed(r)));
    end
    s = 16'($urandom);
    exp = model_sum(s);
    do_pulse(s);
    for (int i = 0; i < 4; i++) tick();
    do_pulse(~s);
    chk("overrun_set", 32'(overrun), 1);
    wait_valid(lat);
    chk("overrun_first_result", 32'($signed(mac_out)), exp);
    count_valids(30, cnt);
    chk("overrun_single_valid", cnt, 0);
    chk("overrun_result_kept", 32'($signed(mac_out)), exp);

    // Randomized timesteps, pulses at minimum spacing where possible.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) begin
        r = 8'($urandom);
        write_w(i, int'($signed(r)));
      end
      s = 16'($urandom);
      do_pulse(s);
      spk_in = 16'($urandom);
      wait_valid(lat);
      chk("rand_latency", lat, 17);
      chk("rand_sum", 32'($signed(mac_out)), model_sum(s));
    end
    chk("overrun_sticky", 32'(overrun), 1);

    // Write to w[3] in the very cycle index 3 is read: old value is used.
    for (int i = 0; i < 16; i++) write_w(i, 2 * i - 15);
    s = 16'h0A0F;
    exp = model_sum(s);
    do_pulse(s);
    for (int i = 0; i < 3; i++) tick();
    write_w(3, 50);
    wait_valid(lat);
    chk("same_cycle_write_old", 32'($signed(mac_out)), exp);
    tick();
    do_pulse(s);
    wait_valid(lat);
    chk("same_cycle_write_next", 32'($signed(mac_out)), model_sum(s));

    // Reset at ACCUM index 7 aborts the sum and clears everything.
    tick();
    do_pulse(16'hFFFF);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) w_m[i] = 0;
    chk("abort_mac_out", 32'($signed(mac_out)), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(mac_valid), 0);
    chk("abort_overrun", 32'(overrun), 0);
    count_valids(25, cnt);
    chk("abort_no_valid", cnt, 0);
    do_pulse(16'hFFFF);
    wait_valid(lat);
    chk("post_abort_latency", lat, 17);
    chk("post_abort_sum", 32'($signed(mac_out)), model_sum(16'hFFFF));
    chk("post_abort_overrun", 32'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
